// File: rtl/log_pkg.sv
// Shared types and helpers for the river-lane log spawn controller.
package log_pkg;

    localparam int unsigned NUM_LOGS_DEF = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } spawn_state_t;

    typedef logic [1:0] level_t;

    // Galois mask for x^16 + x^14 + x^13 + x^11 with a right-shifting register.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [3:0] max_active(input level_t lvl, input int unsigned num_logs);
        int unsigned m;
        m = 32'd2 + 32'd2 * 32'(lvl);
        if (m > num_logs) begin
            m = num_logs;
        end
        return m[3:0];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Move-tick prescaler: one-cycle pulse every (TICK_DIV >> level) cycles while run is high.
module tick_prescaler
    import log_pkg::*;
#(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       run,
    input  logic [1:0] level,
    output logic       tick
);

    localparam int unsigned CntW = $clog2(TICK_DIV);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] last_q, last_d;
    logic            tick_q, tick_d;
    logic            wrap;

    function automatic logic [CntW-1:0] period_last(input level_t lvl);
        return CntW'((TICK_DIV >> lvl) - 32'd1);
    endfunction

    // The period is latched only at wrap (or while stopped), so a level change
    // mid-period takes effect from the next period.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        tick_d = 1'b0;
        wrap   = (cnt_q == last_q);
        if (!run) begin
            cnt_d  = '0;
            last_d = period_last(level);
        end else if (wrap) begin
            cnt_d  = '0;
            last_d = period_last(level);
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q  <= '0;
            last_q <= period_last(2'd0);
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/log_spawn_ctrl.sv
// River-lane log controller: shared move tick, per-slot enables with paced
// spawning, level-capped active count and retirement, plus a random lane selector.
module log_spawn_ctrl
    import log_pkg::*;
#(
    parameter int unsigned NUM_LOGS  = NUM_LOGS_DEF,
    parameter int unsigned TICK_DIV  = 500000,
    parameter int unsigned SPAWN_GAP = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                game_run,
    input  logic [1:0]          level,
    input  logic [NUM_LOGS-1:0] log_off_screen,
    output logic [NUM_LOGS-1:0] log_enable,
    output logic                timer_done,
    output logic [3:0]          random_0_15,
    output logic [3:0]          active_cnt
);

    localparam int unsigned GapW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

    spawn_state_t        state_q, state_d;
    logic [NUM_LOGS-1:0] en_q, en_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [GapW-1:0]     gap_q, gap_d;

    logic                tick;
    logic                presc_run;
    logic [3:0]          max_act;
    logic [NUM_LOGS-1:0] retire_vec, spawn_vec;
    logic                retire_found, spawn_found;

    // Gating with game_run keeps a tick from landing on the edge that leaves RUN.
    assign presc_run = (state_q == RUN) && game_run;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .run   (presc_run),
        .level (level),
        .tick  (tick)
    );

    assign max_act = max_active(level, NUM_LOGS);

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        rnd_d  = tick ? lfsr_q[3:0] : rnd_q;
    end

    // Retire picks the lowest enabled slot that has left the screen.
    always_comb begin
        retire_vec   = '0;
        retire_found = 1'b0;
        if (cnt_q > max_act) begin
            for (int i = 0; i < NUM_LOGS; i++) begin
                if (!retire_found && log_off_screen[i] && en_q[i]) begin
                    retire_vec[i] = 1'b1;
                    retire_found  = 1'b1;
                end
            end
        end
    end

    // Spawn searches the pre-retire enables so a freed slot is reused only later.
    always_comb begin
        spawn_vec   = '0;
        spawn_found = 1'b0;
        if (tick && (gap_q == '0) && (cnt_q < max_act)) begin
            for (int i = 0; i < NUM_LOGS; i++) begin
                if (!spawn_found && !en_q[i]) begin
                    spawn_vec[i] = 1'b1;
                    spawn_found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                en_d  = '0;
                gap_d = '0;
                if (game_run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!game_run) begin
                    state_d = IDLE;
                    en_d    = '0;
                    gap_d   = '0;
                end else begin
                    en_d = (en_q & ~retire_vec) | spawn_vec;
                    if (tick) begin
                        gap_d = (gap_q == GapW'(SPAWN_GAP - 1)) ? '0 : gap_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_LOGS; i++) begin
            cnt_d = cnt_d + {3'b000, en_d[i]};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            en_q    <= '0;
            cnt_q   <= '0;
            rnd_q   <= LFSR_SEED[3:0];
            lfsr_q  <= LFSR_SEED;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            lfsr_q  <= lfsr_d;
            gap_q   <= gap_d;
        end
    end

    assign log_enable  = en_q;
    assign active_cnt  = cnt_q;
    assign random_0_15 = rnd_q;
    assign timer_done  = tick;

endmodule

// File: tb/tb_log_spawn_ctrl.sv
// Scoreboard bench for log_spawn_ctrl: a cycle-level reference model predicts every
// output per clock, a monitor process pops and compares after each rising edge.
module tb_log_spawn_ctrl;

    localparam int NL = 4;
    localparam int TD = 8;
    localparam int SG = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          game_run = 1'b0;
    logic [1:0]    level = 2'd0;
    logic [NL-1:0] log_off_screen = '0;
    logic [NL-1:0] log_enable;
    logic          timer_done;
    logic [3:0]    random_0_15;
    logic [3:0]    active_cnt;

    log_spawn_ctrl #(
        .NUM_LOGS  (NL),
        .TICK_DIV  (TD),
        .SPAWN_GAP (SG),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .game_run       (game_run),
        .level          (level),
        .log_off_screen (log_off_screen),
        .log_enable     (log_enable),
        .timer_done     (timer_done),
        .random_0_15    (random_0_15),
        .active_cnt     (active_cnt)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [NL-1:0] en;
        logic          tick;
        logic [3:0]    rnd;
        logic [3:0]    act;
    } exp_t;

    exp_t sb[$];

    // Reference model state, as seen just after a rising edge.
    bit            m_run;
    int            m_phase;   // cycles elapsed in the current tick period
    int            m_period;  // current tick period in cycles
    bit            m_tick;
    int            m_ticks;   // ticks consumed since entering RUN
    logic [NL-1:0] m_en;
    logic [15:0]   m_lfsr;
    logic [3:0]    m_rnd;

    function automatic void model_reset();
        m_run    = 1'b0;
        m_phase  = 0;
        m_period = TD;
        m_tick   = 1'b0;
        m_ticks  = 0;
        m_en     = '0;
        m_lfsr   = 16'hACE1;
        m_rnd    = 4'h1;
    endfunction

    function automatic void model_step(input bit gr, input logic [1:0] lv, input logic [NL-1:0] off);
        int            maxa;
        int            act;
        logic [NL-1:0] n_en;
        bit            n_tick;
        bit            done;
        maxa   = (2 + 2 * int'(lv) > NL) ? NL : 2 + 2 * int'(lv);
        act    = $countones(m_en);
        n_en   = m_en;
        n_tick = 1'b0;
        m_rnd  = m_tick ? m_lfsr[3:0] : m_rnd;
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        if (!m_run || !gr) begin
            m_run    = !m_run && gr;
            n_en     = '0;
            m_phase  = 0;
            m_period = TD >> lv;
            m_ticks  = 0;
        end else begin
            if (act > maxa) begin
                done = 1'b0;
                for (int i = 0; i < NL; i++) begin
                    if (!done && off[i] && m_en[i]) begin
                        n_en[i] = 1'b0;
                        done = 1'b1;
                    end
                end
            end
            if (m_tick) begin
                if ((m_ticks % SG) == 0 && act < maxa) begin
                    done = 1'b0;
                    for (int i = 0; i < NL; i++) begin
                        if (!done && !m_en[i]) begin
                            n_en[i] = 1'b1;
                            done = 1'b1;
                        end
                    end
                end
                m_ticks++;
            end
            if (m_phase == m_period - 1) begin
                n_tick   = 1'b1;
                m_phase  = 0;
                m_period = TD >> lv;
            end else begin
                m_phase++;
            end
        end
        m_en   = n_en;
        m_tick = n_tick;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the predicted post-edge outputs.
    task automatic cyc(input bit gr, input logic [1:0] lv, input logic [NL-1:0] off);
        exp_t e;
        @(negedge CLK);
        RESET          = 1'b0;
        game_run       = gr;
        level          = lv;
        log_off_screen = off;
        model_step(gr, lv, off);
        e.en   = m_en;
        e.tick = m_tick;
        e.rnd  = m_rnd;
        e.act  = 4'($countones(m_en));
        sb.push_back(e);
    endtask

    task automatic expect_en(input string name, input logic [NL-1:0] want);
        @(posedge CLK);
        #2;
        chk(name, 16'(log_enable), 16'(want));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_enable"}, 16'(log_enable), 16'h0);
        chk({tag, "_tick"}, 16'(timer_done), 16'h0);
        chk({tag, "_random"}, 16'(random_0_15), 16'h1);
        chk({tag, "_active"}, 16'(active_cnt), 16'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("log_enable", 16'(log_enable), 16'(e.en));
                chk("timer_done", 16'(timer_done), 16'(e.tick));
                chk("random_0_15", 16'(random_0_15), 16'(e.rnd));
                chk("active_cnt", 16'(active_cnt), 16'(e.act));
            end
        end
    end

    initial begin : stim
        bit            gr;
        logic [1:0]    lv;
        logic [NL-1:0] off;
        model_reset();
        #1 RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        check_reset_outputs("reset");

        repeat (50) cyc(1'b0, 2'd0, '0);

        repeat (100) cyc(1'b1, 2'd0, '0);
        expect_en("two_active_l0", 4'b0011);

        repeat (60) cyc(1'b1, 2'd3, '0);
        expect_en("full_l3", 4'b1111);

        cyc(1'b1, 2'd0, 4'b0100);
        repeat (3) cyc(1'b1, 2'd0, '0);
        cyc(1'b1, 2'd0, 4'b0001);
        repeat (3) cyc(1'b1, 2'd0, '0);
        cyc(1'b1, 2'd0, 4'b0010);
        repeat (3) cyc(1'b1, 2'd0, '0);
        expect_en("retire_to_two", 4'b1010);

        repeat (3) cyc(1'b1, 2'd0, '0);
        repeat (5) cyc(1'b0, 2'd0, '0);
        repeat (30) cyc(1'b1, 2'd0, '0);
        expect_en("respawn_first_tick", 4'b0001);

        gr = 1'b1;
        lv = 2'd1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) == 0) gr = !gr;
            if ($urandom_range(0, 59) == 0) lv = 2'($urandom_range(0, 3));
            off = ($urandom_range(0, 5) == 0) ? NL'($urandom) : '0;
            cyc(gr, lv, off);
        end

        repeat (30) cyc(1'b1, 2'd3, '0);
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        for (int n = 0; n < 60; n++) begin
            cyc(1'b1, 2'($urandom_range(0, 3)), NL'($urandom));
        end

        repeat (3) @(posedge CLK);
        #2;
        chk("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
